// File: rtl/if_stage_ppl_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID outputs.
// master = the fetch stage, slave = the surrounding datapath / hazard unit / memory.
interface if_stage_ppl_if #(
  parameter int unsigned PC_W    = 30,
  parameter int unsigned INSTR_W = 32
);
  logic               stall;
  logic               flush;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [INSTR_W-1:0] im_rdata;
  logic [PC_W-1:0]    im_addr;
  logic [PC_W-1:0]    PC;
  logic [INSTR_W-1:0] instruction;
  logic [INSTR_W-1:0] ID_instruction;
  logic [PC_W-1:0]    ID_PC;
  logic [PC_W-1:0]    ID_PC_plus1;
  logic               ID_valid;
  logic [31:0]        fetch_count;

  modport master (
    input  stall, flush, redirect, redirect_pc, im_rdata,
    output im_addr, PC, instruction, ID_instruction, ID_PC, ID_PC_plus1, ID_valid, fetch_count
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, im_rdata,
    input  im_addr, PC, instruction, ID_instruction, ID_PC, ID_PC_plus1, ID_valid, fetch_count
  );
endinterface

// File: rtl/if_stage_ppl.sv
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
// Handles load-use stalls, EX redirects (branch/jump) and explicit flushes.
module if_stage_ppl #(
  parameter int unsigned        PC_W      = 30,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic clk,
  input  logic rst,
  if_stage_ppl_if.master bus
);

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_inc;
  logic [INSTR_W-1:0] id_instr_q;
  logic [PC_W-1:0]    id_pc_q;
  logic [PC_W-1:0]    id_pc1_q;
  logic               id_valid_q;
  logic [31:0]        fetch_cnt_q;
  logic               bubble;
  logic               load;

  assign pc_inc = pc_q + PC_W'(1);

  // Redirect dominates stall: the EX branch is older than the ID load-use hazard.
  always_comb begin
    bubble = bus.redirect | bus.flush;
    load   = ~bubble & ~bus.stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      id_instr_q  <= NOP_INSTR;
      id_pc_q     <= '0;
      id_pc1_q    <= '0;
      id_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      if (bus.redirect)
        pc_q <= bus.redirect_pc;
      else if (!bus.stall)
        pc_q <= pc_inc;

      if (bubble) begin
        id_instr_q <= NOP_INSTR;
        id_valid_q <= 1'b0;
      end else if (load) begin
        id_instr_q <= bus.im_rdata;
        id_pc_q    <= pc_q;
        id_pc1_q   <= pc_inc;
        id_valid_q <= 1'b1;
      end

      if (load && (fetch_cnt_q != '1))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.im_addr        = pc_q;
  assign bus.PC             = pc_q;
  assign bus.instruction    = bus.im_rdata;
  assign bus.ID_instruction = id_instr_q;
  assign bus.ID_PC          = id_pc_q;
  assign bus.ID_PC_plus1    = id_pc1_q;
  assign bus.ID_valid       = id_valid_q;
  assign bus.fetch_count    = fetch_cnt_q;

endmodule
